// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multi-cycle multiply/divide responder and the
// execute-stage logic that consumes its results.
//   - md_state_e     : responder FSM states
//   - DATA_W_DEF     : default operand/result width
//   - REG_W_DEF      : default destination register index width
//   - ITER_COUNT     : iterations per operation (one result bit per edge)
//   - EXC_MUL/EXC_DIV: exception codes selected by the execute-side exception
//                      mux when data_exception is raised
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int ITER_COUNT = DATA_W_DEF;

    localparam logic [2:0] EXC_MUL = 3'd4;
    localparam logic [2:0] EXC_DIV = 3'd5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    // Exception code for the execute-side mux, chosen by which op raised it.
    function automatic logic [2:0] exc_code(input logic op_is_div);
        return op_is_div ? EXC_DIV : EXC_MUL;
    endfunction

endpackage : md_pkg

// File: rtl/md_sign_fix.sv
// -----------------------------------------------------------------------------
// md_sign_fix
// Combinational two's-complement conditional negation. Used both as an
// absolute-value unit (negate_i tied to the operand's sign bit) and as the
// final sign correction of a magnitude result.
//   data_i   : W-bit input value
//   negate_i : 1 = output the two's-complement negation of data_i
//   data_o   : W-bit result
// The most negative value maps to itself, which read as unsigned is exactly
// its magnitude, so the unsigned datapath downstream handles it unchanged.
// -----------------------------------------------------------------------------
module md_sign_fix
    import md_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] data_i,
    input  logic         negate_i,
    output logic [W-1:0] data_o
);

    assign data_o = negate_i ? ((~data_i) + W'(1)) : data_i;

endmodule : md_sign_fix

// File: rtl/md_iter_unit.sv
// -----------------------------------------------------------------------------
// md_iter_unit
// Multi-cycle signed multiply/divide responder for the execute stage's MD
// handshake. A start is sampled only in IDLE; the unit then runs exactly
// DATA_W iterations on operand magnitudes, applies the sign in FIX and
// presents the result with a one-cycle data_resultRDY pulse in DONE.
// Latency from start edge back to IDLE is a fixed DATA_W+2 edges.
//
// Ports
//   clock             : system clock, rising edge
//   reset             : asynchronous active-low reset (0 = reset)
//   data_operandA     : multiplicand / dividend
//   data_operandB     : multiplier / divisor
//   ctrl_MULT         : start multiply (wins if ctrl_DIV also high)
//   ctrl_DIV          : start divide
//   ctrl_writeReg_in  : destination register of the started op
//   data_result       : signed result, valid while data_resultRDY=1
//   data_exception    : overflow / divide-by-zero, valid while data_resultRDY=1
//   data_resultRDY    : one-cycle completion pulse
//   is_mult / is_div  : op in flight, from start edge through DONE inclusive
//   ctrl_writeReg_out : destination register latched at the start edge
//   busy              : state != IDLE
// -----------------------------------------------------------------------------
module md_iter_unit
    import md_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [REG_W-1:0]  ctrl_writeReg_in,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              is_mult,
    output logic              is_div,
    output logic [REG_W-1:0]  ctrl_writeReg_out,
    output logic              busy
);

    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    md_state_e           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   mag_a_q;
    logic [DATA_W-1:0]   mag_b_q;
    logic                sign_a_q;
    logic                sign_b_q;
    // Multiply: {partial high, remaining multiplier bits / low product}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [PROD_W-1:0]   acc_q;
    logic [DATA_W-1:0]   result_q;
    logic                exc_q;
    logic                rdy_q;
    logic                is_mult_q;
    logic                is_div_q;
    logic [REG_W-1:0]    wreg_q;

    // ------------------------------------------------------------------
    // Operand magnitudes, computed from the raw inputs at the start edge
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;

    md_sign_fix #(.W(DATA_W)) u_abs_a (
        .data_i   (data_operandA),
        .negate_i (data_operandA[DATA_W-1]),
        .data_o   (abs_a)
    );

    md_sign_fix #(.W(DATA_W)) u_abs_b (
        .data_i   (data_operandB),
        .negate_i (data_operandB[DATA_W-1]),
        .data_o   (abs_b)
    );

    // ------------------------------------------------------------------
    // One iteration step for each operation
    // ------------------------------------------------------------------
    logic [DATA_W:0]   mul_sum;
    logic [PROD_W-1:0] mul_acc_d;
    logic [DATA_W:0]   div_shift;
    logic              div_fits;
    logic [DATA_W-1:0] div_rem_sub;
    logic [PROD_W-1:0] div_acc_d;

    // NOTE: every signal driven here gets a value on every path before any
    // branch, so no storage (latch) can be inferred.
    always_comb begin
        mul_sum     = '0;
        mul_acc_d   = acc_q;
        div_shift   = '0;
        div_fits    = 1'b0;
        div_rem_sub = '0;
        div_acc_d   = acc_q;

        // Shift-add: add the multiplicand into the high half when the
        // multiplier bit at acc_q[0] is set, then shift the whole thing
        // right; the 33-bit sum keeps the carry.
        mul_sum   = {1'b0, acc_q[PROD_W-1:DATA_W]}
                  + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_acc_d = {mul_sum, acc_q[DATA_W-1:1]};

        // Restoring division: bring the next dividend bit into the
        // remainder; subtract the divisor only if it fits. The true
        // difference is below 2^DATA_W, so a DATA_W-bit subtract suffices.
        div_shift   = acc_q[PROD_W-1:DATA_W-1];
        div_fits    = (div_shift >= {1'b0, mag_b_q});
        div_rem_sub = div_shift[DATA_W-1:0] - mag_b_q;
        if (div_fits) begin
            div_acc_d = {div_rem_sub, acc_q[DATA_W-2:0], 1'b1};
        end else begin
            div_acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and exception detection, consumed in FIX
    // ------------------------------------------------------------------
    logic              res_neg;
    logic [PROD_W-1:0] fix_in;
    logic [PROD_W-1:0] fix_out;
    logic              mul_ovf;
    logic              div_exc;
    logic              exc_d;
    logic [DATA_W-1:0] result_d;

    assign res_neg = sign_a_q ^ sign_b_q;
    // Divide only needs the quotient corrected; the remainder is dropped.
    assign fix_in  = is_mult_q ? acc_q : {{DATA_W{1'b0}}, acc_q[DATA_W-1:0]};

    md_sign_fix #(.W(PROD_W)) u_fix (
        .data_i   (fix_in),
        .negate_i (res_neg),
        .data_o   (fix_out)
    );

    // Signed product fits in DATA_W bits only if the high half is pure
    // sign extension of the low half.
    assign mul_ovf  = (fix_out[PROD_W-1:DATA_W] != {DATA_W{fix_out[DATA_W-1]}});
    // Divide-by-zero, or MOST_NEG / -1 whose quotient is not representable.
    assign div_exc  = (mag_b_q == '0)
                   || (sign_a_q && (mag_a_q == MOST_NEG)
                       && sign_b_q && (mag_b_q == DATA_W'(1)));
    assign exc_d    = is_mult_q ? mul_ovf : div_exc;
    assign result_d = exc_d ? '0 : fix_out[DATA_W-1:0];

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: all state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath registers are reset too, so an abandoned
            // op leaves nothing visible and outputs read 0 from reset on.
            state_q   <= IDLE;
            cnt_q     <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            acc_q     <= '0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            is_mult_q <= 1'b0;
            is_div_q  <= 1'b0;
            wreg_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b0;
                    if (ctrl_MULT || ctrl_DIV) begin
                        cnt_q     <= '0;
                        mag_a_q   <= abs_a;
                        mag_b_q   <= abs_b;
                        sign_a_q  <= data_operandA[DATA_W-1];
                        sign_b_q  <= data_operandB[DATA_W-1];
                        wreg_q    <= ctrl_writeReg_in;
                        is_mult_q <= ctrl_MULT;
                        is_div_q  <= !ctrl_MULT;
                        if (ctrl_MULT) begin
                            // Multiply wins a simultaneous request.
                            state_q <= MUL;
                            acc_q   <= {{DATA_W{1'b0}}, abs_b};
                        end else begin
                            state_q <= DIV;
                            acc_q   <= {{DATA_W{1'b0}}, abs_a};
                        end
                    end
                end
                MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                DIV: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= result_d;
                    exc_q    <= exc_d;
                    rdy_q    <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    // Start requests are ignored here; they are taken
                    // again from the following IDLE cycle.
                    rdy_q     <= 1'b0;
                    is_mult_q <= 1'b0;
                    is_div_q  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    rdy_q     <= 1'b0;
                    is_mult_q <= 1'b0;
                    is_div_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign data_result       = result_q;
    assign data_exception    = exc_q;
    assign data_resultRDY    = rdy_q;
    assign is_mult           = is_mult_q;
    assign is_div            = is_div_q;
    assign ctrl_writeReg_out = wreg_q;
    assign busy              = (state_q != IDLE);

endmodule : md_iter_unit

// File: tb/tb_md_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_md_iter_unit
// Directed bench for md_iter_unit. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
// "After Ek" below means the falling edge following the k-th rising edge
// counted from the start edge E0.
// -----------------------------------------------------------------------------
module tb_md_iter_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [4:0]  ctrl_writeReg_in;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        is_mult;
    logic        is_div;
    logic [4:0]  ctrl_writeReg_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    md_iter_unit dut (
        .clock             (clock),
        .reset             (reset),
        .data_operandA     (data_operandA),
        .data_operandB     (data_operandB),
        .ctrl_MULT         (ctrl_MULT),
        .ctrl_DIV          (ctrl_DIV),
        .ctrl_writeReg_in  (ctrl_writeReg_in),
        .data_result       (data_result),
        .data_exception    (data_exception),
        .data_resultRDY    (data_resultRDY),
        .is_mult           (is_mult),
        .is_div            (is_div),
        .ctrl_writeReg_out (ctrl_writeReg_out),
        .busy              (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the start is sampled on the next rising edge
    // (E0) and the task returns on the falling edge after E0. Operand inputs
    // are then scrambled so that only latched values can produce the result.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r);
        ctrl_MULT        = m;
        ctrl_DIV         = d;
        data_operandA    = a;
        data_operandB    = b;
        ctrl_writeReg_in = r;
        @(negedge clock);
        ctrl_MULT        = 1'b0;
        ctrl_DIV         = 1'b0;
        data_operandA    = 32'hDEAD_BEEF;
        data_operandB    = 32'h1234_5678;
        ctrl_writeReg_in = 5'h1F;
    endtask

    // Full operation: start, wait for the ready pulse (bounded), check the
    // result cycle, then step once into IDLE and check the release.
    // div_poke = k pulses ctrl_DIV so that it is sampled at Ek;
    // done_poke pulses ctrl_DIV during the DONE cycle.
    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp_res,
                          input bit exp_exc, input int div_poke,
                          input bit done_poke, output int rdy_at);
        int lat;
        bit flag_bad;
        bit exp_m;
        bit exp_d;
        exp_m    = m;
        exp_d    = !m && d;
        lat      = -1;
        rdy_at   = -1;
        flag_bad = 1'b0;
        start_op(m, d, a, b, r);
        if (is_mult !== exp_m || is_div !== exp_d || busy !== 1'b1) flag_bad = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (div_poke != 0 && c == div_poke - 1) ctrl_DIV = 1'b1;
            if (div_poke != 0 && c == div_poke) ctrl_DIV = 1'b0;
            if (is_mult !== exp_m || is_div !== exp_d || busy !== 1'b1) flag_bad = 1'b1;
            if (data_resultRDY === 1'b1) begin
                lat    = c;
                rdy_at = cyc;
                break;
            end
        end
        check({tag, " ready latency"}, 64'(lat), 64'd33);
        check({tag, " op flags/busy during op"}, 64'(flag_bad), 64'd0);
        check({tag, " result"}, 64'(data_result), 64'(exp_res));
        check({tag, " exception"}, 64'(data_exception), 64'(exp_exc));
        check({tag, " writeReg_out"}, 64'(ctrl_writeReg_out), 64'(r));
        if (done_poke) begin
            ctrl_DIV      = 1'b1;
            data_operandA = 32'd50;
            data_operandB = 32'd5;
        end
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check({tag, " ready low after DONE"}, 64'(data_resultRDY), 64'd0);
        check({tag, " busy low after DONE"}, 64'(busy), 64'd0);
        check({tag, " is_mult/is_div low after DONE"}, 64'({is_mult, is_div}), 64'd0);
        check({tag, " result held"}, 64'(data_result), 64'(exp_res));
        check({tag, " writeReg_out held"}, 64'(ctrl_writeReg_out), 64'(r));
    endtask

    initial begin
        int t1;
        int t2;
        int dummy;
        bit rst_bad;

        reset            = 1'b0;
        data_operandA    = '0;
        data_operandB    = '0;
        ctrl_MULT        = 1'b0;
        ctrl_DIV         = 1'b0;
        ctrl_writeReg_in = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset result", 64'(data_result), 64'd0);
        check("reset exception", 64'(data_exception), 64'd0);
        check("reset ready", 64'(data_resultRDY), 64'd0);
        check("reset is_mult/is_div", 64'({is_mult, is_div}), 64'd0);
        check("reset writeReg_out", 64'(ctrl_writeReg_out), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Multiply: 7 * -3 = -21
        run_op("mul 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 5'd9,
               32'hFFFF_FFEB, 1'b0, 0, 1'b0, dummy);
        // 65536 * 65536 = 2^32 overflows
        run_op("mul ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 5'd2,
               32'h0000_0000, 1'b1, 0, 1'b0, dummy);
        // -65536 * 32768 = -2^31, exactly representable
        run_op("mul most-neg", 1, 0, 32'hFFFF_0000, 32'h0000_8000, 5'd3,
               32'h8000_0000, 1'b0, 0, 1'b0, dummy);
        // 100 / -7 = -14 (truncation toward zero)
        run_op("div 100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 5'd4,
               32'hFFFF_FFF2, 1'b0, 0, 1'b0, dummy);
        // 5 / 0
        run_op("div by zero", 0, 1, 32'd5, 32'd0, 5'd5,
               32'h0000_0000, 1'b1, 0, 1'b0, dummy);
        // most negative / -1
        run_op("div ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,
               32'h0000_0000, 1'b1, 0, 1'b0, dummy);
        // Both starts: multiply wins; ctrl_DIV sampled at E5 is ignored
        run_op("mul+div start", 1, 1, 32'd6, 32'd3, 5'd7,
               32'd18, 1'b0, 5, 1'b0, dummy);
        repeat (3) @(negedge clock);
        check("no second op busy", 64'(busy), 64'd0);
        check("no second op ready", 64'(data_resultRDY), 64'd0);

        // Reset in the middle of a divide
        start_op(0, 1, 32'd100, 32'd7, 5'd8);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid-op reset result", 64'(data_result), 64'd0);
        check("mid-op reset exception", 64'(data_exception), 64'd0);
        check("mid-op reset ready", 64'(data_resultRDY), 64'd0);
        check("mid-op reset is_mult/is_div", 64'({is_mult, is_div}), 64'd0);
        check("mid-op reset busy", 64'(busy), 64'd0);
        check("mid-op reset writeReg_out", 64'(ctrl_writeReg_out), 64'd0);
        rst_bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) rst_bad = 1'b1;
        end
        check("no ready while held in reset", 64'(rst_bad), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        run_op("div 9/2 after reset", 0, 1, 32'd9, 32'd2, 5'd10,
               32'd4, 1'b0, 0, 1'b0, dummy);

        // Back-to-back: DIV request in DONE ignored, new MULT right after
        run_op("b2b first", 1, 0, 32'd3, 32'd4, 5'd11,
               32'd12, 1'b0, 0, 1'b1, t1);
        run_op("b2b second", 1, 0, 32'd5, 32'd5, 5'd12,
               32'd25, 1'b0, 0, 1'b0, t2);
        check("b2b cycles between ready pulses", 64'(t2 - t1 - 1), 64'd34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_md_iter_unit

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Multi-cycle signed multiply/divide responder for the execute stage's MD handshake.
- Accepts a one-cycle start (ctrl_MULT or ctrl_DIV) with operands and destination register.
- Iterates for a fixed 32 cycles, then presents result, exception flag and destination register with a one-cycle ready pulse.
- While it is busy, the pipeline holds and uses is_mult/is_div to gate writeback.

Parameters:
DATA_W, 32, operand/result width; iteration count equals DATA_W
REG_W, 5, destination register index width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
data_operandA  input  DATA_W  multiplicand / dividend
data_operandB  input  DATA_W  multiplier / divisor
ctrl_MULT  input  1  start multiply; sampled only in IDLE
ctrl_DIV  input  1  start divide; sampled only in IDLE
ctrl_writeReg_in  input  REG_W  destination register of the started op
data_result  output  DATA_W  signed result, valid while data_resultRDY=1
data_exception  output  1  overflow or divide-by-zero, valid while data_resultRDY=1
data_resultRDY  output  1  one-cycle completion pulse
is_mult  output  1  multiply in flight (start edge through DONE cycle inclusive)
is_div  output  1  divide in flight (start edge through DONE cycle inclusive)
ctrl_writeReg_out  output  REG_W  latched destination register
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs are 0, including data_result.
  - Counter and operand registers are cleared.
  - An in-flight op is abandoned; no data_resultRDY is produced.
- States and transitions:
  - IDLE -> MUL when ctrl_MULT=1 at an edge.
  - IDLE -> DIV when ctrl_DIV=1 and ctrl_MULT=0.
  - If both are 1, MULT wins and DIV is dropped.
  - MUL/DIV -> FIX after 32 iteration edges (6-bit counter 0..31).
  - FIX -> DONE; DONE -> IDLE.
- Start edge E0:
  - Latch |A|, |B|, the sign bits, the op type and ctrl_writeReg_in.
  - is_mult or is_div rises after E0.
- Iterations E1..E32: one bit per edge.
  - MUL: shift-add on magnitudes into a 64-bit accumulator.
  - DIV: restoring division on magnitudes, giving 32-bit quotient and remainder.
- E33 (FIX -> DONE):
  - Apply sign: negate the product when signA^signB; negate the quotient when signA^signB.
  - Remainder is discarded; quotient truncates toward zero.
  - Register data_result and data_exception; data_resultRDY=1 for exactly the cycle after E33.
- E34: back to IDLE; data_resultRDY, is_mult, is_div and busy fall to 0.
- Latency is fixed at 34 edges from start to IDLE, independent of operand values; no early termination.
- Exceptions:
  - MUL: signed 64-bit product[63:32] is not all copies of product[31].
  - DIV: divisor == 0, or A == 0x80000000 with B == 0xFFFFFFFF.
  - When the exception is set, data_result is forced to 0.
- Handshake rules:
  - ctrl_MULT/ctrl_DIV are ignored whenever state != IDLE, including the DONE cycle.
  - A start in the cycle after DONE (IDLE) is accepted.
- Holding values:
  - ctrl_writeReg_out holds its latched value from E0 until the next start.
  - data_result and data_exception hold their last value after DONE until the next FIX.
- Magnitude of 0x80000000 is 0x80000000 interpreted as unsigned; the unsigned datapath must handle it.

Decomposition:
- Shared package md_pkg:
  - state enum: IDLE, MUL, DIV, FIX, DONE.
  - DATA_W and REG_W defaults.
  - Exception code constants EXC_MUL=4, EXC_DIV=5, used by the execute-side exception mux.
  - Iteration count constant.
- One sub-module, md_sign_fix:
  - Combinational two's-complement absolute value and conditional negation.
  - Instantiated for operand magnitude at E0 and for result sign correction at FIX.

Test Plan:
- Multiply 7 × -3, ctrl_writeReg_in=9:
  - data_resultRDY high only in the cycle after the 33rd edge following the start edge.
  - data_result=0xFFFFFFEB, data_exception=0, ctrl_writeReg_out=9.
  - is_mult high from after E0 through the DONE cycle.
- Multiply 65536 × 65536 -> data_exception=1, data_result=0; -65536 × 32768 -> 0x80000000, exception 0.
- Divide 100 / -7 -> 0xFFFFFFF2 (-14); divide 5 / 0 -> exception=1, result=0; divide 0x80000000 / 0xFFFFFFFF -> exception=1.
- Both starts asserted in IDLE with A=6, B=3 -> multiply runs, result 18, is_div stays 0. A ctrl_DIV pulse at E5 during the op is ignored: no second op, busy falls at E34.
- Drive reset=0 mid-divide at E10 -> all outputs 0 immediately, no ready pulse. Release reset and start 9 / 2 -> result 4 at the standard latency.
- Back-to-back starts: new ctrl_MULT in the cycle right after DONE is accepted; the ready pulses are separated by exactly 34 cycles.
